// File: rtl/div_unit.sv
// RV32M divide/remainder unit: radix-2 restoring divider with valid/ready result handshake.
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_signed, is_rem, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     rem_shift, rem_sub;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next, dvd_next, quot_fix, rem_fix;
  logic              unused_f3;

  assign unused_f3 = funct3[2];
  assign is_signed = ~funct3[0];
  assign is_rem    = funct3[1];
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign abs_a     = a_neg ? (-a) : a;
  assign abs_b     = b_neg ? (-b) : b;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (b == '0) begin
      special     = 1'b1;
      special_res = is_rem ? a : '1;
    end else if (is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b)) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : a;
    end
`ifdef DIV_EARLY_OUT_EN
    else if (abs_a < abs_b) begin
      special     = 1'b1;
      special_res = is_rem ? a : '0;
    end
`endif
  end

  // One restoring step; the borrow bit of the trial subtract is the inverted quotient bit.
  assign rem_shift = {rem_q, dvd_q[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, dsr_q};
  assign q_bit     = ~rem_sub[XLEN];
  assign rem_next  = q_bit ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign dvd_next  = {dvd_q[XLEN-2:0], q_bit};
  assign quot_fix  = q_neg_q ? (-dvd_next) : dvd_next;
  assign rem_fix   = r_neg_q ? (-rem_next) : rem_next;

  always_comb begin
    state_d  = state_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          is_rem_d = is_rem;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            dvd_d   = abs_a;
            dsr_d   = abs_b;
            rem_d   = '0;
            cnt_d   = CntW'(XLEN);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = is_rem_q ? rem_fix : quot_fix;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Kill wins over everything, including a same-cycle request.
    if (flush) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCalc) || (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected results, monitor checks on handshake.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int EoLat = 1;
`else
  localparam int EoLat = 33;
`endif

  typedef struct {
    string       nm;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  funct3 = 3'd4;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .funct3    (funct3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare at every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h expected none", result);
        end else begin
          e = exp_q.pop_front();
          check(e.nm, {32'h0, result}, {32'h0, e.val});
        end
      end
    end
  end

  // lat==0: accept only (no expectation, no wait); otherwise wait for out_valid and check latency.
  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] exp, input int lat);
    int   n;
    logic busy_ok;
    @(negedge clk);
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    funct3   = f;
    if (lat > 0) exp_q.push_back('{nm, exp});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    funct3   = {1'b1, 2'($urandom)};
    if (lat > 0) begin
      n       = 1;
      busy_ok = 1'b1;
      while (!out_valid && n < 100) begin
        if (!busy || in_ready) busy_ok = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
      check({nm, "_lat"}, 64'(n), 64'(lat));
      check({nm, "_busy"}, {63'h0, busy_ok}, 64'h1);
    end
  endtask

  task automatic drain(input string nm);
    @(posedge clk);
    #1;
    check({nm, "_idle"}, {61'h0, out_valid, busy, in_ready}, 64'b001);
  endtask

  initial begin
    logic seen;
    #2;
    check("reset_outs", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue("div_42_6", 3'd4, 32'd42, 32'd6, 32'd7, 33);                drain("div_42_6");
    issue("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);   drain("rem_m7_2");
    issue("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);   drain("div_m7_2");
    issue("remu_max_10", 3'd7, 32'hFFFFFFFF, 32'd10, 32'd5, 33);      drain("remu_max_10");
    issue("div_min_2", 3'd4, 32'h80000000, 32'd2, 32'hC0000000, 33);  drain("div_min_2");
    issue("divu_by0", 3'd5, 32'd42, 32'd0, 32'hFFFFFFFF, 1);          drain("divu_by0");
    issue("rem_by0", 3'd6, 32'd43, 32'd0, 32'd43, 1);                 drain("rem_by0");
    issue("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); drain("div_ovf");
    issue("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);     drain("rem_ovf");

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue("bp", 3'd5, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_hold", {30'h0, in_ready, out_valid, result}, {30'h0, 1'b0, 1'b1, 32'h7FFFFFFF});
    end
    out_ready = 1'b1;
    drain("bp");

    // Flush at CALC cycle 15: nothing must ever come out.
    issue("fl", 3'd4, 32'd1000, 32'd3, 32'd0, 0);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", {61'h0, out_valid, busy, in_ready}, 64'b001);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_out", {63'h0, seen}, 64'h0);

    // Flush beats a same-cycle request.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    a        = 32'd100;
    b        = 32'd7;
    funct3   = 3'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_req", {61'h0, out_valid, busy, in_ready}, 64'b001);

    issue("div_100_7", 3'd4, 32'd100, 32'd7, 32'd14, 33);            drain("div_100_7");

    // Asynchronous reset in the middle of CALC; result was 14 before.
    issue("rs", 3'd6, 32'd12345, 32'd17, 32'd0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst = 1'b0;

    issue("divu_3_10", 3'd5, 32'd3, 32'd10, 32'd0, EoLat);           drain("divu_3_10");
    issue("remu_3_10", 3'd7, 32'd3, 32'd10, 32'd3, EoLat);           drain("remu_3_10");
    issue("rem_m3_10", 3'd6, 32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, EoLat); drain("rem_m3_10");

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
